block_cnt_stats: RTL and testbench
==================================

Name: block_cnt_stats

Overview:
Downstream consumer of the bit-block counter stage. It takes the per-word block count `cnt_in`/`cnt_vld` and accumulates window statistics over `WIN_LEN` valid words: saturating sum, maximum, and the number of words with a non-zero count. Each completed window is published through a registered valid/ready output with a one-entry holding register. Unaccepted results are reported through a sticky overrun flag.

Parameters:
- WIN_LEN, 16, number of valid input words per statistics window (2..255).
- SUM_W, 8, width of the saturating sum accumulator and output.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset
- cnt_in  input  4  block count of the current word from the upstream counter
- cnt_vld  input  1  cnt_in qualifier; one word per cycle when high
- clr  input  1  synchronous abort: discards the current window and clears flags
- stat_sum  output  SUM_W  saturating sum of cnt_in over the window
- stat_max  output  4  maximum cnt_in in the window
- stat_nz  output  8  count of window words with cnt_in != 0
- stat_vld  output  1  result valid
- stat_rdy  input  1  consumer accepts the result when stat_vld && stat_rdy
- overrun  output  1  sticky: a completed window was dropped

Behaviour:
- Reset rst_n, asynchronous, active-low; clock clk.
- Reset clears every output and internal register to 0: stat_sum, stat_max, stat_nz, stat_vld, overrun, accumulators, word counter. FSM goes to IDLE.
- FSM states: IDLE (no word in current window) and ACCUM (1..WIN_LEN-1 words taken).
  - IDLE -> ACCUM on cnt_vld.
  - ACCUM -> IDLE on the cycle the WIN_LEN-th cnt_vld is sampled (window close).
  - Any state -> IDLE on clr.
- Accumulation on each cnt_vld:
  - sum = min(sum + cnt_in, 2^SUM_W-1)
  - max = max(max, cnt_in)
  - nz += (cnt_in != 0)
  - word counter increments.
- The first word of a window loads the accumulators directly; there is no residue from the prior window.
- Window close:
  - The closing word is included in the result.
  - The result is loaded into the output registers and stat_vld=1 on the next clock edge, i.e. latency 1 cycle after the last sample.
  - Accumulators and the word counter restart, so a word on the following cycle begins the next window. There are no bubbles.
- Output handshake:
  - Output registers hold stable while stat_vld && !stat_rdy.
  - stat_vld drops the cycle after acceptance unless a new result loads in the same cycle.
- Boundary conditions:
  - Close while stat_vld && !stat_rdy: the new result is dropped, the held result is kept, and overrun is set to 1 (sticky).
  - Close in the same cycle as acceptance (stat_vld && stat_rdy): the new result loads and stat_vld stays 1 with no gap. overrun is not set.
  - clr and cnt_vld in the same cycle: clr wins and the sample is discarded.
  - clr also clears stat_vld and overrun; output data registers go to 0.
  - cnt_vld low: no state change. Gaps inside a window are allowed.
  - Asynchronous reset mid-window discards all partial state immediately.
- stat_nz width 8 covers WIN_LEN up to 255.

Optional Feature:
- BLK_STATS_MIN_EN defined: adds output port `stat_min[3:0]` (minimum cnt_in in the window).
  - Tracked like max; the first word loads it.
  - Reset value 0; cleared by clr; held under backpressure like the other outputs.
- Undefined: port and logic are absent. All other behaviour is identical.

Decomposition:
- Package `blk_stats_pkg`:
  - CNT_W=4
  - FSM state typedef (IDLE, ACCUM)
  - result struct typedef (sum, max, nz, optional min)
  - function `sat_add` (saturating add, parameterised by width)
- One sub-module, `blk_stats_accum`: the accumulator datapath (sum/max/nz/min plus word counter, close pulse out).
- The top holds the FSM, output register, handshake and overrun.

Test Plan:
- WIN_LEN=4, SUM_W=8, stat_rdy=1; cnt_in 3,0,10,5 on consecutive cycles -> one cycle after the 4th word: stat_vld=1, sum=18, max=10, nz=3, overrun=0.
- WIN_LEN=4, SUM_W=4; cnt_in 10,10,10,10 -> sum=15 (saturated), max=10, nz=4.
- WIN_LEN=2, stat_rdy=0; windows {1,2} then {4,4} -> held result sum=3, max=2, nz=2 stays stable; overrun=1 after the second close. Raise stat_rdy -> stat_vld drops next cycle, overrun stays 1 until clr.
- WIN_LEN=2, continuous cnt_vld with values 1,1,2,2; stat_rdy pulsed exactly on the second close cycle -> stat_vld stays 1 continuously, second result sum=4, overrun=0.
- WIN_LEN=4; words 7,7 then clr together with a cnt_vld of 9, then 1,1,1,1 -> the discarded window never appears; result sum=4, max=1, nz=4.
- Assert rst_n low mid-window with stat_vld=1 -> all outputs 0 immediately. After release, a fresh window of 2,2,2,2 (WIN_LEN=4) -> sum=8. With BLK_STATS_MIN_EN, also check min for 3,0,10,5 -> 0.

Source files
------------

// File: rtl/blk_stats_pkg.sv
// ----------------------------------------------------------------------------
// blk_stats_pkg : shared types and helpers for the block-count statistics slice
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package blk_stats_pkg;

  localparam int CNT_W  = 4;
  localparam int NZ_W   = 8;
  localparam int WCNT_W = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Window result fields; the sum is carried alongside at the instance's SUM_W.
  typedef struct packed {
    logic [CNT_W-1:0] max;
    logic [NZ_W-1:0]  nz;
`ifdef BLK_STATS_MIN_EN
    logic [CNT_W-1:0] min;
`endif
  } blk_stats_t;

  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] s;
    logic [32:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (s > lim) ? lim[31:0] : s[31:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/blk_stats_accum.sv
// ----------------------------------------------------------------------------
// blk_stats_accum : window accumulators (sum/max/nz/min) and word counter
// Rev 1.0  (min tracking present when BLK_STATS_MIN_EN is defined)
// ----------------------------------------------------------------------------
`default_nettype none

module blk_stats_accum
  import blk_stats_pkg::*;
#(
  parameter int WIN_LEN = 16,
  parameter int SUM_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             cnt_vld,
  input  logic             clr,
  input  logic             first_i,
  output logic [SUM_W-1:0] sum_o,
  output blk_stats_t       fld_o,
  output logic             close_o
);

  logic [SUM_W-1:0]  sum_q, sum_d;
  blk_stats_t        fld_q, fld_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              w_nz;
  logic              w_take;

  assign w_nz    = (cnt_in != '0);
  assign w_take  = cnt_vld && !clr;
  assign close_o = w_take && (wcnt_q == WCNT_W'(WIN_LEN - 1));

  // Window value including the current word; the first word ignores residue.
  always_comb begin
    fld_o = fld_q;
    if (first_i) begin
      sum_o     = SUM_W'(sat_add(32'd0, 32'(cnt_in), SUM_W));
      fld_o.max = cnt_in;
      fld_o.nz  = NZ_W'(w_nz);
`ifdef BLK_STATS_MIN_EN
      fld_o.min = cnt_in;
`endif
    end else begin
      sum_o     = SUM_W'(sat_add(32'(sum_q), 32'(cnt_in), SUM_W));
      fld_o.max = (cnt_in > fld_q.max) ? cnt_in : fld_q.max;
      fld_o.nz  = fld_q.nz + NZ_W'(w_nz);
`ifdef BLK_STATS_MIN_EN
      fld_o.min = (cnt_in < fld_q.min) ? cnt_in : fld_q.min;
`endif
    end
  end

  always_comb begin
    sum_d  = sum_q;
    fld_d  = fld_q;
    wcnt_d = wcnt_q;
    if (clr || close_o) begin
      sum_d  = '0;
      fld_d  = '0;
      wcnt_d = '0;
    end else if (cnt_vld) begin
      sum_d  = sum_o;
      fld_d  = fld_o;
      wcnt_d = wcnt_q + WCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      fld_q  <= '0;
      wcnt_q <= '0;
    end else begin
      sum_q  <= sum_d;
      fld_q  <= fld_d;
      wcnt_q <= wcnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/block_cnt_stats.sv
// ----------------------------------------------------------------------------
// block_cnt_stats : windowed block-count statistics with valid/ready output
// Rev 1.0  (BLK_STATS_MIN_EN adds the stat_min output)
// ----------------------------------------------------------------------------
`default_nettype none

module block_cnt_stats
  import blk_stats_pkg::*;
#(
  parameter int WIN_LEN = 16,
  parameter int SUM_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             cnt_vld,
  input  logic             clr,
  output logic [SUM_W-1:0] stat_sum,
  output logic [CNT_W-1:0] stat_max,
  output logic [NZ_W-1:0]  stat_nz,
  output logic             stat_vld,
  input  logic             stat_rdy,
  output logic             overrun
`ifdef BLK_STATS_MIN_EN
  ,
  output logic [CNT_W-1:0] stat_min
`endif
);

  state_e           state_q, state_d;
  logic [SUM_W-1:0] acc_sum;
  blk_stats_t       acc_fld;
  logic             close;

  logic [SUM_W-1:0] sum_q, sum_d;
  blk_stats_t       fld_q, fld_d;
  logic             vld_q, vld_d;
  logic             ovr_q, ovr_d;

  blk_stats_accum #(
    .WIN_LEN (WIN_LEN),
    .SUM_W   (SUM_W)
  ) u_accum (
    .clk     (clk),
    .rst_n   (rst_n),
    .cnt_in  (cnt_in),
    .cnt_vld (cnt_vld),
    .clr     (clr),
    .first_i (state_q == IDLE),
    .sum_o   (acc_sum),
    .fld_o   (acc_fld),
    .close_o (close)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cnt_vld && !clr) state_d = ACCUM;
      ACCUM:   if (clr || close)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A close that meets a stalled result is dropped and flagged; a close that
  // meets an accepted result replaces it without a valid gap.
  always_comb begin
    sum_d = sum_q;
    fld_d = fld_q;
    vld_d = vld_q;
    ovr_d = ovr_q;
    if (clr) begin
      sum_d = '0;
      fld_d = '0;
      vld_d = 1'b0;
      ovr_d = 1'b0;
    end else begin
      if (vld_q && stat_rdy) vld_d = 1'b0;
      if (close) begin
        if (vld_q && !stat_rdy) begin
          ovr_d = 1'b1;
        end else begin
          sum_d = acc_sum;
          fld_d = acc_fld;
          vld_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      fld_q   <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      fld_q   <= fld_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
    end
  end

  assign stat_sum = sum_q;
  assign stat_max = fld_q.max;
  assign stat_nz  = fld_q.nz;
  assign stat_vld = vld_q;
  assign overrun  = ovr_q;
`ifdef BLK_STATS_MIN_EN
  assign stat_min = fld_q.min;
`endif

endmodule

`default_nettype wire

// File: tb/tb_block_cnt_stats.sv
// ----------------------------------------------------------------------------
// tb_block_cnt_stats : directed scoreboard bench over three configurations
// Rev 1.0  (checks stat_min when BLK_STATS_MIN_EN is defined)
// ----------------------------------------------------------------------------
`default_nettype none

module tb_block_cnt_stats;

  typedef struct {
    int         inst;
    logic [7:0] sum;
    logic [3:0] max;
    logic [7:0] nz;
    logic [3:0] min;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] cin  [3];
  logic       cvld [3];
  logic       cclr [3];
  logic       rdy  [3];
  logic [7:0] o_sum[3];
  logic [3:0] o_max[3];
  logic [7:0] o_nz [3];
  logic       o_vld[3];
  logic       o_ovr[3];
  logic [3:0] o_min[3];

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // Instance 0: WIN_LEN=4 SUM_W=8; 1: WIN_LEN=4 SUM_W=4; 2: WIN_LEN=2 SUM_W=8
  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int WL = (gi == 2) ? 2 : 4;
    localparam int SW = (gi == 1) ? 4 : 8;
    logic [SW-1:0] w_sum;
    assign o_sum[gi] = 8'(w_sum);
`ifndef BLK_STATS_MIN_EN
    assign o_min[gi] = 4'd0;
`endif
    block_cnt_stats #(.WIN_LEN(WL), .SUM_W(SW)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cnt_in   (cin[gi]),
      .cnt_vld  (cvld[gi]),
      .clr      (cclr[gi]),
      .stat_sum (w_sum),
      .stat_max (o_max[gi]),
      .stat_nz  (o_nz[gi]),
      .stat_vld (o_vld[gi]),
      .stat_rdy (rdy[gi]),
      .overrun  (o_ovr[gi])
`ifdef BLK_STATS_MIN_EN
      ,
      .stat_min (o_min[gi])
`endif
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int inst, input int s, input int mx, input int nz, input int mn);
    exp_t e;
    e.inst = inst;
    e.sum  = 8'(s);
    e.max  = 4'(mx);
    e.nz   = 8'(nz);
    e.min  = 4'(mn);
    sb.push_back(e);
  endtask

  // Any result that will be accepted at the coming edge is popped and compared.
  task automatic mon();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (o_vld[i] && rdy[i]) begin
        n_cmp++;
        assert (sb.size() != 0) else begin
          n_err++;
          $error("FAIL sb_underflow: dut %0d offered sum %0d, expected no result", i, o_sum[i]);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk($sformatf("res_inst%0d", i), i, e.inst);
          chk($sformatf("res_sum%0d", i), o_sum[i], e.sum);
          chk($sformatf("res_max%0d", i), o_max[i], e.max);
          chk($sformatf("res_nz%0d", i), o_nz[i], e.nz);
`ifdef BLK_STATS_MIN_EN
          chk($sformatf("res_min%0d", i), o_min[i], e.min);
`endif
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input int i, input int v);
    cin[i]  = 4'(v);
    cvld[i] = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cin[i] = '0; cvld[i] = 1'b0; cclr[i] = 1'b0; rdy[i] = 1'b0;
    end
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_vld%0d", i), o_vld[i], 0);
      chk($sformatf("rst_sum%0d", i), o_sum[i], 0);
      chk($sformatf("rst_ovr%0d", i), o_ovr[i], 0);
    end
    rst_n = 1'b1;
    tick();

    // Basic window
    rdy[0] = 1'b1;
    push(0, 18, 10, 3, 0);
    word(0, 3); word(0, 0); word(0, 10); word(0, 5);
    cvld[0] = 1'b0;
    chk("s1_vld", o_vld[0], 1);
    chk("s1_ovr", o_ovr[0], 0);
    tick();
    chk("s1_vld_drop", o_vld[0], 0);

    // Saturation at SUM_W=4
    rdy[1] = 1'b1;
    push(1, 15, 10, 4, 10);
    for (int k = 0; k < 4; k++) word(1, 10);
    cvld[1] = 1'b0;
    chk("s2_vld", o_vld[1], 1);
    tick();

    // Backpressure and overrun
    word(2, 1); word(2, 2);
    chk("s3_vld", o_vld[2], 1);
    chk("s3_ovr0", o_ovr[2], 0);
    word(2, 4); word(2, 4);
    cvld[2] = 1'b0;
    chk("s3_ovr1", o_ovr[2], 1);
    chk("s3_hold_sum", o_sum[2], 3);
    chk("s3_hold_max", o_max[2], 2);
    chk("s3_hold_nz", o_nz[2], 2);
    tick();
    chk("s3_hold_vld", o_vld[2], 1);
    push(2, 3, 2, 2, 1);
    rdy[2] = 1'b1;
    tick();
    rdy[2] = 1'b0;
    chk("s3_vld_drop", o_vld[2], 0);
    chk("s3_ovr_sticky", o_ovr[2], 1);
    cclr[2] = 1'b1;
    tick();
    cclr[2] = 1'b0;
    chk("s3_clr_ovr", o_ovr[2], 0);

    // Close coincident with acceptance
    push(2, 2, 1, 2, 1);
    push(2, 4, 2, 2, 2);
    word(2, 1); word(2, 1);
    chk("s4_vld_a", o_vld[2], 1);
    word(2, 2);
    chk("s4_vld_b", o_vld[2], 1);
    rdy[2] = 1'b1;
    word(2, 2);
    cvld[2] = 1'b0;
    rdy[2]  = 1'b0;
    chk("s4_vld_c", o_vld[2], 1);
    chk("s4_sum2", o_sum[2], 4);
    chk("s4_ovr", o_ovr[2], 0);
    rdy[2] = 1'b1;
    tick();
    rdy[2] = 1'b0;
    chk("s4_vld_drop", o_vld[2], 0);

    // clr beats a simultaneous sample
    rdy[0] = 1'b1;
    push(0, 4, 1, 4, 1);
    word(0, 7); word(0, 7);
    cclr[0] = 1'b1;
    word(0, 9);
    cclr[0] = 1'b0;
    chk("s5_vld_clr", o_vld[0], 0);
    for (int k = 0; k < 4; k++) word(0, 1);
    cvld[0] = 1'b0;
    chk("s5_vld", o_vld[0], 1);
    tick();

    // Asynchronous reset mid-window with a held result
    rdy[0] = 1'b0;
    for (int k = 0; k < 4; k++) word(0, 2);
    word(0, 5);
    cvld[0] = 1'b0;
    chk("s6_pre_vld", o_vld[0], 1);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_vld", o_vld[0], 0);
    chk("s6_rst_sum", o_sum[0], 0);
    chk("s6_rst_max", o_max[0], 0);
    chk("s6_rst_nz", o_nz[0], 0);
    chk("s6_rst_ovr", o_ovr[0], 0);
    tick();
    rst_n  = 1'b1;
    rdy[0] = 1'b1;
    push(0, 8, 2, 4, 2);
    for (int k = 0; k < 4; k++) word(0, 2);
    cvld[0] = 1'b0;
    chk("s6_vld", o_vld[0], 1);
    tick();
    chk("s6_vld_drop", o_vld[0], 0);

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
